// File: rtl/multicycle_datapath.sv
// Multicycle RV64-subset core: own regfile, ALU and sequencer on one req/ack memory port; ALU 4, load 5, store 4, branch 3 cycles.
// Requests hold until mem_ack, so any memory latency is absorbed; RETIRE_COUNTER_EN adds the instret output.
module multicycle_datapath #(
   parameter int          WORDSIZE         = 64,
   parameter int          INSTRUCTION_SIZE = 32,
   parameter int          REG_COUNT        = 32,
   parameter int unsigned RESET_PC         = 0,
   parameter int unsigned PC_STEP          = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                mem_req,
   output logic                mem_we,
   output logic [WORDSIZE-1:0] mem_addr,
   output logic [WORDSIZE-1:0] mem_wdata,
   input  logic [WORDSIZE-1:0] mem_rdata,
   input  logic                mem_ack,
   output logic [WORDSIZE-1:0] pc,
   output logic                halted,
   output logic                illegal,
   output logic [WORDSIZE-1:0] result,
   output logic [6:0]          opcode
`ifdef RETIRE_COUNTER_EN
  ,output logic [WORDSIZE-1:0] instret
`endif
);

   localparam int RW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam logic [WORDSIZE-1:0] RST_PC = WORDSIZE'(RESET_PC);
   localparam logic [WORDSIZE-1:0] STEP   = WORDSIZE'(PC_STEP);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   typedef struct packed {
      logic alu_r;
      logic load;
      logic store;
      logic branch;
      logic stop;
      logic legal;
   } dec_t;

   state_t state_q, state_d;
   dec_t   dec;

   logic [INSTRUCTION_SIZE-1:0] ir;
   logic [WORDSIZE-1:0]         regs [REG_COUNT];
   logic [WORDSIZE-1:0]         op_a, op_b, imm_q, alu_q, addr_q;
   logic [WORDSIZE-1:0]         imm_i, imm_s, imm_b, imm_d, rhs, alu_y;
   logic [6:0]                  opc;
   logic [2:0]                  funct3;
   logic [RW-1:0]               rs1_idx, rs2_idx, rd_idx;
   logic                        take;

   assign opc     = ir[6:0];
   assign funct3  = ir[14:12];
   assign rd_idx  = ir[7 +: RW];
   assign rs1_idx = ir[15 +: RW];
   assign rs2_idx = ir[20 +: RW];
   assign opcode  = opc;

   assign imm_i = {{(WORDSIZE-12){ir[31]}}, ir[31:20]};
   assign imm_s = {{(WORDSIZE-12){ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{(WORDSIZE-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

   always_comb begin
      dec   = '0;
      imm_d = imm_i;
      case (opc)
         7'b0110011: begin
            dec.alu_r = 1'b1;
            dec.legal = 1'b1;
         end
         7'b0010011: dec.legal = funct3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
         7'b0000011: begin
            dec.load  = 1'b1;
            dec.legal = (funct3 == 3'b011);
         end
         7'b0100011: begin
            dec.store = 1'b1;
            dec.legal = (funct3 == 3'b011);
            imm_d     = imm_s;
         end
         7'b1100011: begin
            dec.branch = 1'b1;
            dec.legal  = funct3 inside {3'b000, 3'b001, 3'b100, 3'b101};
            imm_d      = imm_b;
         end
         7'b0000000: begin
            dec.stop  = 1'b1;
            dec.legal = 1'b1;
         end
         default: dec.legal = 1'b0;
      endcase
   end

   // funct7[5] (ir[30]) only selects SUB/SRA for register-register forms
   always_comb begin
      rhs   = dec.alu_r ? op_b : imm_q;
      alu_y = '0;
      case (funct3)
         3'b000:  alu_y = (dec.alu_r && ir[30]) ? op_a - rhs : op_a + rhs;
         3'b001:  alu_y = op_a << op_b[5:0];
         3'b010:  alu_y = {{(WORDSIZE-1){1'b0}}, $signed(op_a) < $signed(rhs)};
         3'b011:  alu_y = {{(WORDSIZE-1){1'b0}}, op_a < rhs};
         3'b100:  alu_y = op_a ^ rhs;
         3'b101:  alu_y = ir[30] ? WORDSIZE'($signed(op_a) >>> op_b[5:0]) : op_a >> op_b[5:0];
         3'b110:  alu_y = op_a | rhs;
         default: alu_y = op_a & rhs;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  take = (op_a == op_b);
         3'b001:  take = (op_a != op_b);
         3'b100:  take = ($signed(op_a) < $signed(op_b));
         3'b101:  take = ($signed(op_a) >= $signed(op_b));
         default: take = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_FETCH;
         S_FETCH:  if (mem_ack) state_d = S_DECODE;
         S_DECODE: state_d = (dec.stop || !dec.legal) ? S_HALT : S_EXEC;
         S_EXEC: begin
            if (dec.load || dec.store) state_d = S_MEM;
            else if (dec.branch)       state_d = S_FETCH;
            else                       state_d = S_WB;
         end
         S_MEM:    if (mem_ack) state_d = dec.load ? S_WB : S_FETCH;
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   // Request fields come only from registered state, so they cannot move while waiting for mem_ack
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      halted    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc;
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_addr = addr_q;
            if (dec.store) begin
               mem_we    = 1'b1;
               mem_wdata = op_b;
            end
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RST_PC;
         ir      <= '0;
         op_a    <= '0;
         op_b    <= '0;
         imm_q   <= '0;
         alu_q   <= '0;
         addr_q  <= '0;
         result  <= '0;
         illegal <= 1'b0;
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else begin
         case (state_q)
            S_FETCH: if (mem_ack) ir <= mem_rdata[INSTRUCTION_SIZE-1:0];
            S_DECODE: begin
               op_a  <= regs[rs1_idx];
               op_b  <= regs[rs2_idx];
               imm_q <= imm_d;
               if (!dec.legal) illegal <= 1'b1;
            end
            S_EXEC: begin
               alu_q  <= alu_y;
               addr_q <= op_a + imm_q;
               if (dec.branch) pc <= take ? pc + imm_q : pc + STEP;
            end
            S_MEM: begin
               if (mem_ack) begin
                  if (dec.load) alu_q <= mem_rdata;
                  else          pc    <= pc + STEP;
               end
            end
            S_WB: begin
               if (rd_idx != '0) regs[rd_idx] <= alu_q;
               result <= alu_q;
               pc     <= pc + STEP;
            end
            default: ;
         endcase
      end
   end

`ifdef RETIRE_COUNTER_EN
   logic retire;
   assign retire = (state_q == S_WB)
                || (state_q == S_EXEC && dec.branch)
                || (state_q == S_MEM && mem_ack && dec.store);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      instret <= '0;
      else if (retire) instret <= instret + WORDSIZE'(1);
   end
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: program images, wait-state memory model, queued expectations for reads, stores and writebacks.
module tb_multicycle_datapath;
   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         mem_req, mem_we, mem_ack, halted, illegal;
   logic [W-1:0] mem_addr, mem_wdata, mem_rdata, pc, result;
   logic [6:0]   opcode;
`ifdef RETIRE_COUNTER_EN
   logic [W-1:0] instret;
`endif

   always #5 clk = ~clk;

   multicycle_datapath dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .pc(pc), .halted(halted), .illegal(illegal), .result(result), .opcode(opcode)
`ifdef RETIRE_COUNTER_EN
     ,.instret(instret)
`endif
   );

   // memory: program image plus a store overlay; ack after wait_cfg stall cycles
   logic [31:0]  prog [128];
   logic [W-1:0] data [128];
   bit           data_vld [128];
   int           wait_cfg = 0;
   int           wait_cnt = 0;
   logic [6:0]   midx;

   assign midx      = mem_addr[8:2];
   assign mem_ack   = mem_req && (wait_cnt == wait_cfg);
   assign mem_rdata = data_vld[midx] ? data[midx] : {32'h0, prog[midx]};

   always @(posedge clk) begin
      if (!mem_req || mem_ack) wait_cnt <= 0;
      else                     wait_cnt <= wait_cnt + 1;
      if (!rst_n) begin
         for (int i = 0; i < 128; i++) data_vld[i] <= 1'b0;
      end else if (mem_req && mem_we && mem_ack) begin
         data[midx]     <= mem_wdata;
         data_vld[midx] <= 1'b1;
      end
   end

   logic [W-1:0] exp_rd[$], exp_wb[$], exp_st_addr[$], exp_st_dat[$];
   int n_checks = 0;
   int n_fails  = 0;
   int st_hold  = 0;
   bit wb_pend  = 1'b0;

   task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         wb_pend = 1'b0;
         st_hold = 0;
      end else begin
         if (wb_pend) begin
            check_val("wb_avail", W'(exp_wb.size() != 0), 1);
            if (exp_wb.size() != 0) check_val("wb_result", result, exp_wb.pop_front());
            wb_pend = 1'b0;
         end
         if (dut.state_q == 3'd5) wb_pend = 1'b1;
         if (mem_req && mem_we) begin
            if (exp_st_addr.size() != 0 && mem_addr == exp_st_addr[0] && mem_wdata == exp_st_dat[0])
               st_hold++;
            if (mem_ack) begin
               check_val("st_avail", W'(exp_st_addr.size() != 0), 1);
               if (exp_st_addr.size() != 0) begin
                  check_val("st_addr", mem_addr, exp_st_addr.pop_front());
                  check_val("st_data", mem_wdata, exp_st_dat.pop_front());
               end
               check_val("st_hold_cycles", W'(st_hold), W'(wait_cfg + 1));
               st_hold = 0;
            end
         end
         if (mem_req && !mem_we && mem_ack) begin
            check_val("rd_avail", W'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0) check_val("rd_addr", mem_addr, exp_rd.pop_front());
         end
      end
   end

   function automatic logic [31:0] enc_i(input int rd, input int rs1, input logic [2:0] f3, input int imm);
      logic [11:0] i12;
      i12 = 12'(imm);
      return {i12, 5'(rs1), f3, 5'(rd), 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2, input logic [2:0] f3, input logic [6:0] f7);
      return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_ld(input int rd, input int rs1, input logic [2:0] f3, input int imm);
      logic [11:0] i12;
      i12 = 12'(imm);
      return {i12, 5'(rs1), f3, 5'(rd), 7'b0000011};
   endfunction

   function automatic logic [31:0] enc_sd(input int rs2, input int rs1, input int imm);
      logic [11:0] s12;
      s12 = 12'(imm);
      return {s12[11:5], 5'(rs2), 5'(rs1), 3'b011, s12[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input int rs1, input int rs2, input logic [2:0] f3, input int imm);
      logic [12:0] b13;
      b13 = 13'(imm);
      return {b13[12], b13[10:5], 5'(rs2), 5'(rs1), f3, b13[4:1], b13[11], 7'b1100011};
   endfunction

   task automatic do_reset(input int wc);
      rst_n    = 1'b0;
      start    = 1'b0;
      wait_cfg = wc;
      exp_rd.delete();
      exp_wb.delete();
      exp_st_addr.delete();
      exp_st_dat.delete();
      for (int i = 0; i < 128; i++) prog[i] = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_halt(input int budget, output int cycles);
      cycles = 0;
      while (!halted && cycles < budget) begin
         @(posedge clk);
         cycles++;
         #1;
      end
      check_val("halt_reached", W'(halted), 1);
      @(negedge clk);
   endtask

   task automatic end_test(input int retired);
      check_val("rd_left", W'(exp_rd.size()), 0);
      check_val("wb_left", W'(exp_wb.size()), 0);
      check_val("st_left", W'(exp_st_addr.size()), 0);
`ifdef RETIRE_COUNTER_EN
      check_val("instret", instret, W'(retired));
`endif
   endtask

   int cyc;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no end expected end");
      $fatal(1);
   end

   initial begin
      // ADDI chain with reset state and exact cycle timing
      do_reset(0);
      prog[0] = enc_i(1, 0, 3'b000, 5);
      prog[1] = enc_i(2, 1, 3'b000, -7);
      exp_rd = '{0, 4, 8};
      exp_wb = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFE};
      check_val("rst_pc", pc, 0);
      check_val("rst_halted", W'(halted), 0);
      check_val("rst_illegal", W'(illegal), 0);
      check_val("rst_result", result, 0);
      check_val("rst_mem_req", W'(mem_req), 0);
      check_val("rst_mem_we", W'(mem_we), 0);
      check_val("rst_mem_addr", mem_addr, 0);
      check_val("rst_mem_wdata", mem_wdata, 0);
      check_val("rst_opcode", W'(opcode), 0);
`ifdef RETIRE_COUNTER_EN
      check_val("rst_instret", instret, 0);
`endif
      repeat (3) @(negedge clk);
      check_val("idle_no_req", W'(mem_req), 0);
      pulse_start();
      repeat (7) @(posedge clk);
      @(negedge clk);
      check_val("pc_after_7", pc, 4);
      @(posedge clk);
      @(negedge clk);
      check_val("pc_after_8", pc, 8);
      wait_halt(200, cyc);
      cyc += 8;
      check_val("addi_cycles", W'(cyc), 10);
      check_val("clean_halt_illegal", W'(illegal), 0);
      check_val("clean_halt_pc", pc, 8);
      end_test(2);

      // R-type and immediate ALU coverage
      do_reset(0);
      prog[0]  = enc_i(1, 0, 3'b000, 5);
      prog[1]  = enc_i(2, 0, 3'b000, 3);
      prog[2]  = enc_r(3, 1, 2, 3'b000, 7'h20);
      prog[3]  = enc_r(4, 2, 1, 3'b010, 7'h00);
      prog[4]  = enc_r(5, 3, 4, 3'b101, 7'h20);
      prog[5]  = enc_r(6, 0, 1, 3'b000, 7'h20);
      prog[6]  = enc_r(7, 6, 4, 3'b101, 7'h20);
      prog[7]  = enc_r(8, 6, 4, 3'b101, 7'h00);
      prog[8]  = enc_r(9, 1, 6, 3'b011, 7'h00);
      prog[9]  = enc_r(10, 6, 1, 3'b010, 7'h00);
      prog[10] = enc_r(11, 1, 2, 3'b100, 7'h00);
      prog[11] = enc_r(12, 1, 2, 3'b111, 7'h00);
      prog[12] = enc_r(13, 1, 2, 3'b110, 7'h00);
      prog[13] = enc_r(14, 1, 4, 3'b001, 7'h00);
      prog[14] = enc_r(0, 1, 2, 3'b000, 7'h00);
      prog[15] = enc_i(15, 0, 3'b000, 7);
      prog[16] = enc_i(16, 6, 3'b111, 15);
      prog[17] = enc_i(17, 6, 3'b010, -4);
      prog[18] = enc_i(18, 0, 3'b110, -1);
      prog[19] = enc_i(19, 1, 3'b100, -1);
      prog[20] = enc_r(20, 1, 6, 3'b010, 7'h00);
      for (int i = 0; i <= 21; i++) exp_rd.push_back(W'(4 * i));
      exp_wb = '{64'd5, 64'd3, 64'd2, 64'd1, 64'd1,
                 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFD, 64'h7FFF_FFFF_FFFF_FFFD,
                 64'd1, 64'd1, 64'd6, 64'd1, 64'd7, 64'd10, 64'd8, 64'd7,
                 64'hB, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA, 64'd0};
      pulse_start();
      wait_halt(500, cyc);
      check_val("alu_cycles", W'(cyc), 86);
      check_val("alu_halt_pc", pc, 84);
      end_test(21);

      // store then load with three wait states on every access
      do_reset(3);
      prog[0] = enc_i(1, 0, 3'b000, 5);
      prog[1] = enc_sd(1, 0, 16);
      prog[2] = enc_ld(6, 0, 3'b011, 16);
      exp_rd = '{0, 4, 8, 16, 12};
      exp_wb = '{64'd5, 64'd5};
      exp_st_addr = '{64'd16};
      exp_st_dat  = '{64'd5};
      pulse_start();
      wait_halt(500, cyc);
      check_val("mem_cycles", W'(cyc), 33);
      check_val("mem_halt_pc", pc, 12);
      end_test(3);

      // branches: taken forward, taken backward, not taken, signed compares
      do_reset(0);
      prog[0] = enc_i(1, 0, 3'b000, 1);
      prog[1] = enc_i(2, 0, 3'b000, 2);
      prog[2] = enc_b(0, 0, 3'b000, 16);
      prog[3] = 32'h0000_007F;
      prog[4] = enc_b(1, 1, 3'b001, 8);
      prog[5] = enc_b(1, 2, 3'b100, 12);
      prog[6] = enc_b(1, 1, 3'b000, -8);
      prog[8] = enc_b(1, 2, 3'b101, 8);
      exp_rd = '{0, 4, 8, 24, 16, 20, 32, 36};
      exp_wb = '{64'd1, 64'd2};
      pulse_start();
      wait_halt(500, cyc);
      check_val("br_cycles", W'(cyc), 25);
      check_val("br_halt_pc", pc, 36);
      check_val("br_illegal", W'(illegal), 0);
      end_test(7);

      // unsupported opcode halts with illegal set and ignores start
      do_reset(0);
      prog[0] = enc_i(1, 0, 3'b000, 1);
      prog[1] = 32'h0000_007F;
      exp_rd = '{0, 4};
      exp_wb = '{64'd1};
      pulse_start();
      wait_halt(200, cyc);
      check_val("ill_halted", W'(halted), 1);
      check_val("ill_flag", W'(illegal), 1);
      check_val("ill_opcode", W'(opcode), 64'h7F);
      pulse_start();
      repeat (5) @(negedge clk);
      check_val("ill_pc_frozen", pc, 4);
      check_val("ill_still_halted", W'(halted), 1);
      check_val("ill_no_req", W'(mem_req), 0);
      end_test(1);

      // load with an unsupported width is illegal
      do_reset(0);
      prog[0] = enc_ld(3, 0, 3'b010, 0);
      exp_rd = '{0};
      pulse_start();
      wait_halt(200, cyc);
      check_val("lw_illegal", W'(illegal), 1);
      check_val("lw_pc", pc, 0);
      end_test(0);

      // asynchronous reset while a load is stalled
      do_reset(20);
      prog[0] = enc_i(1, 0, 3'b000, 5);
      prog[1] = enc_ld(6, 0, 3'b011, 16);
      exp_rd = '{0, 4};
      exp_wb = '{64'd5};
      pulse_start();
      cyc = 0;
      while (!(mem_req && mem_addr == 16) && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check_val("ld_req_seen", W'(mem_req && mem_addr == 16), 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("arst_mem_req", W'(mem_req), 0);
      check_val("arst_pc", pc, 0);
      check_val("arst_state", W'(dut.state_q), 0);
      check_val("arst_result", result, 0);
      end_test(0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
